// File: rtl/sat_mac_pkg.sv
// sat_mac_pkg: shared state encoding, accumulator sizing and saturation limits for sat_mac.
package sat_mac_pkg;
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;
  function automatic int acc_w(input int w, input int taps);
    return 2 * w + $clog2(taps);
  endfunction
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/sat_rescale.sv
// sat_rescale: arithmetic shift of the accumulator back to Q format, clamped to the result width.
module sat_rescale import sat_mac_pkg::*; #(
  parameter int f = 10,
  parameter int Width = 16,
  parameter int AW = 35
) (
  input  logic [AW-1:0]    acc,
  output logic [Width-1:0] y,
  output logic             sat
);
  localparam logic signed [AW-1:0] MX = AW'(sat_max(Width));
  localparam logic signed [AW-1:0] MN = AW'(sat_min(Width));
  logic signed [AW-1:0] sh;
  logic hi, lo;
  always_comb begin
    sh = $signed(acc) >>> f;
    hi = sh > MX;
    lo = sh < MN;
    sat = hi | lo;
    y = hi ? MX[Width-1:0] : lo ? MN[Width-1:0] : sh[Width-1:0];
  end
endmodule

// File: rtl/sat_mac.sv
// sat_mac: burst multiply-accumulate with full-precision accumulation and a single saturating rescale at the end.
module sat_mac import sat_mac_pkg::*; #(
  parameter int f = 10,
  parameter int p = 5,
  parameter int Width = f + p + 1,
  parameter int Taps = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] Y,
  output logic             sat
);
  localparam int AW = acc_w(Width, Taps);
  localparam int PW = 2 * Width;
  localparam int CW = $clog2(Taps + 1);
  state_t state, nxt;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc;
  logic p_vld, p_first, p_last, acc_done;
  logic [CW-1:0] cnt;
  logic take, close, sat_c;
  logic [Width-1:0] y_c;
  sat_rescale #(.f(f), .Width(Width), .AW(AW)) u_rescale (.acc(acc), .y(y_c), .sat(sat_c));
  always_comb begin
    in_ready = rst_n && (state == IDLE || state == ACC);
    take = in_valid && in_ready;
    close = take && (in_last || cnt == CW'(Taps - 1));
    nxt = state;
    if (state == IDLE && take) nxt = close ? DRAIN : ACC;
    else if (state == ACC && close) nxt = DRAIN;
    else if (state == DRAIN && acc_done) nxt = OUT;
    else if (state == OUT && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prod <= '0;
      acc <= '0;
      cnt <= '0;
      p_vld <= 1'b0;
      p_first <= 1'b0;
      p_last <= 1'b0;
      acc_done <= 1'b0;
      out_valid <= 1'b0;
      Y <= '0;
      sat <= 1'b0;
    end else begin
      state <= nxt;
      p_vld <= take;
      p_first <= take && state == IDLE;
      p_last <= close;
      acc_done <= p_vld && p_last;
      cnt <= close ? '0 : take ? cnt + CW'(1) : cnt;
      if (take) prod <= PW'($signed(A)) * PW'($signed(B));
      // first product of a burst overwrites so no clear cycle is needed between bursts
      if (p_vld) acc <= p_first ? AW'(prod) : acc + AW'(prod);
      if (state == DRAIN && acc_done) begin
        Y <= y_c;
        sat <= sat_c;
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  end
endmodule
